// File: rtl/reg_dump_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_dump_pkg
//  Purpose  : Shared types and constants for the register-file dump reader.
//             Holds the dump FSM state encoding and the default register
//             count.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package reg_dump_pkg;

    localparam int REG_DUMP_AW    = 5;
    localparam int REG_DUMP_NREGS = 2 ** REG_DUMP_AW;

    // SUM is only reachable when the checksum word is built in.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        SUM  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/reg_dump_xor_acc.sv
`default_nettype none
// ============================================================================
//  Module   : reg_dump_xor_acc
//  Purpose  : XOR accumulator used to build the dump checksum word.
//  Ports    : clk, rst      - clock, synchronous active-high reset
//             clear         - zero the accumulator (has priority over en)
//             en            - fold data into the accumulator this edge
//             data [DATA_W] - word to fold in
//             acc  [DATA_W] - registered running XOR
//  Revision : 1.0  initial release
// ============================================================================
module reg_dump_xor_acc #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] acc
);

    logic [DATA_W-1:0] r_acc;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= r_acc ^ data;
        end
    end

    assign acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/reg_dump.sv
`default_nettype none
// ============================================================================
//  Module   : reg_dump
//  Purpose  : Debug reader for the register file. A start pulse stalls the
//             core, walks addresses 0..2^AW-1 on read port A and streams each
//             word over a valid/ready handshake tagged with its index, then
//             pulses done for one cycle.
//  Config   : REG_DUMP_CHECKSUM_EN - when defined, a final word with index
//             2^AW carrying the XOR of all dumped words is appended.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             start               - dump request (honoured only when idle)
//             stall               - core hold while a dump is running
//             Ra   [AW]           - register file port A address
//             busA [DATA_W]       - register file port A read data
//             out_valid/out_ready - output handshake
//             out_data [DATA_W]   - dumped word
//             out_idx  [AW+1]     - index of out_data (2^AW = checksum)
//             done                - one-cycle completion pulse
//  Revision : 1.0  initial release
// ============================================================================
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AW     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              stall,
    output logic [AW-1:0]     Ra,
    input  logic [DATA_W-1:0] busA,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [AW:0]       out_idx,
    output logic              done
);

    localparam logic [AW:0] c_LAST_IDX = (AW+1)'(2 ** AW - 1);

    state_t            r_state;
    logic [AW:0]       r_idx;
    logic              r_stall;
    logic              r_outValid;
    logic [DATA_W-1:0] r_outData;
    logic [AW:0]       r_outIdx;
    logic              r_done;

    logic              w_handshake;

    assign w_handshake = r_outValid && out_ready;

`ifdef REG_DUMP_CHECKSUM_EN
    localparam logic [AW:0] c_SUM_IDX = (AW+1)'(2 ** AW);

    logic [DATA_W-1:0] w_acc;
    logic              w_accClear;
    logic              w_accEn;

    // Clear on an accepted start; fold each word in as it is captured.
    assign w_accClear = (r_state == IDLE) && start;
    assign w_accEn    = (r_state == LOAD);

    reg_dump_xor_acc #(
        .DATA_W (DATA_W)
    ) u_xorAcc (
        .clk   (clk),
        .rst   (rst),
        .clear (w_accClear),
        .en    (w_accEn),
        .data  (busA),
        .acc   (w_acc)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_stall    <= 1'b0;
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outIdx   <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_idx   <= '0;
                        r_stall <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    // Ra has been driving r_idx for a full cycle; busA is settled.
                    r_outData  <= busA;
                    r_outIdx   <= r_idx;
                    r_outValid <= 1'b1;
                    r_state    <= SEND;
                end
                SEND: begin
                    if (w_handshake) begin
                        r_outValid <= 1'b0;
                        if (r_idx != c_LAST_IDX) begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= LOAD;
                        end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                            // The last word was folded in at its LOAD edge,
                            // so the accumulator is already final here.
                            r_outData  <= w_acc;
                            r_outIdx   <= c_SUM_IDX;
                            r_outValid <= 1'b1;
                            r_state    <= SUM;
`else
                            r_done  <= 1'b1;
                            r_state <= DONE;
`endif
                        end
                    end
                end
                SUM: begin
                    if (w_handshake) begin
                        r_outValid <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    r_stall <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign stall     = r_stall;
    assign Ra        = r_idx[AW-1:0];
    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_idx   = r_outIdx;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: doc/reg_dump.md
# reg_dump

Debug reader for the 32×32-bit register file. On a `start` pulse it stalls the core and walks addresses 0..31 on the register file's read port A. It streams each word out over a valid/ready handshake tagged with its index, then pulses `done`. It sits beside the datapath and drives `Ra`/consumes `busA` while the core is held by `stall`.

## Interface
- `DATA_W`, 32, register width
- `AW`, 5, register address width; dump covers 2^AW registers
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to begin a dump; ignored unless idle
- `stall`  out  1  high while a dump is in progress; core must suppress `RegWr`
- `Ra`  out  AW  read address to register file port A
- `busA`  in  DATA_W  combinational read data for `Ra`
- `out_valid`  out  1  `out_data`/`out_idx` hold a word
- `out_ready`  in  1  sink accepts the word this cycle
- `out_data`  out  DATA_W  dumped word
- `out_idx`  out  AW+1  register index of `out_data`; value 2^AW = checksum word
- `done`  out  1  one-cycle pulse after the final word is accepted

## Operation
- States: IDLE, LOAD, SEND, SUM (checksum build only), DONE.
- IDLE: `stall`=0, `out_valid`=0. `start`=1 → LOAD, idx←0, `stall`←1.
- LOAD: `Ra`=idx. At edge: `out_data`←`busA`, `out_idx`←idx, `out_valid`←1 → SEND.
- SEND: outputs frozen while `out_ready`=0. Handshake = `out_valid`&&`out_ready`. On handshake, `out_valid`←0:
  - idx<2^AW−1 → idx+1, LOAD
  - idx=2^AW−1 → SUM if checksum built, else DONE
- DONE: `done`=1 for exactly one cycle, `stall`←0 → IDLE.
- `Ra` outside LOAD = idx (don't-care to the register file; kept stable).
- idx counter is AW+1 bits; no wrap. Register 0 is dumped like any other (reads 0).
- `start` in any non-IDLE state is ignored. `start` in the DONE cycle is ignored.
- `rst` at any point: → IDLE, with `stall`=0, `out_valid`=0, `done`=0, `out_data`=0, `out_idx`=0, `Ra`=0, idx=0. A partially sent dump is abandoned without `done`.

## Timing
- `start` sampled at edge k → `stall`=1 after k. LOAD during cycle k..k+1; `out_valid`=1 after edge k+1.
- Each word costs LOAD + SEND ≥ 2 cycles. With `out_ready` tied high, the 32-word dump spans 64 cycles from `start` to the last handshake. `done` is high for the cycle after it.
- `out_data`/`out_idx` are registered and never change while `out_valid`=1 and `out_ready`=0.
- `out_valid` never deasserts without a handshake (except reset).
- `busA` must settle within one cycle of `Ra` (combinational read).

## Configuration
- `REG_DUMP_CHECKSUM_EN` defined: XOR accumulator cleared on `start`, XORs each word at its LOAD capture. SUM state presents accumulator with `out_idx`=2^AW, same handshake, then DONE. Dump = 33 words.
- Undefined: no accumulator, no SUM state. Dump = 2^AW words. `out_idx` MSB is always 0.

## Structure
- Package `reg_dump_pkg`: state enum (IDLE, LOAD, SEND, SUM, DONE) and localparam `REG_DUMP_NREGS` = 2^AW.
- One natural sub-module: `reg_dump_xor_acc` (clear/enable/data in, DATA_W accumulator out). Instantiated only under `REG_DUMP_CHECKSUM_EN`.

## Test plan
- Register file preloaded with reg[i]=0x1000_0000+i, `out_ready`=1, pulse `start` → 32 words, idx 0..31, reg0 reads 0x0, `done` one cycle after idx 31 accepted, `stall` high throughout.
- Backpressure: `out_ready`=0 for 5 cycles while idx=7 presented → `out_data`/`out_idx` stable, then one handshake only, next word idx 8.
- `start` re-pulsed at idx 10 and in the DONE cycle → ignored, exactly one dump, one `done`.
- `rst` asserted at idx 20 → next cycle all outputs 0, state IDLE, no `done`. A new `start` begins again at idx 0.
- With `REG_DUMP_CHECKSUM_EN`, reg[i]=i → 33rd word has `out_idx`=32 and `out_data`=XOR(0..31)=0x0. With reg[5]=0xFFFF_FFFF instead, checksum is 0xFFFF_FFFA.
- Without the macro → exactly 32 handshakes, `out_idx`[5] never 1.
